// File: rtl/icache_refill.sv
// Instruction-cache line refill: one 16-beat burst per miss, critical-word forwarding,
// and a single-cycle write of {tag, line} with its valid bit into the line RAM.
module icache_refill #(
    parameter int unsigned INDEX_SIZE    = 6,
    parameter int unsigned WORD_OFF_SIZE = 4,
    parameter int unsigned TAG_SIZE      = 20
) (
    input  logic                                           clk,
    input  logic                                           resetn,
    input  logic                                           miss_req,
    input  logic [31:0]                                    miss_addr,
    output logic                                           refill_busy,
    output logic                                           refill_done,
    output logic                                           crit_valid,
    output logic [31:0]                                    crit_data,
    output logic                                           protocol_err,
    output logic                                           mem_rd_req,
    output logic [31:0]                                    mem_rd_addr,
    input  logic                                           mem_rd_gnt,
    input  logic                                           mem_rvalid,
    input  logic [31:0]                                    mem_rdata,
    input  logic                                           mem_rlast,
    output logic                                           ram_wen,
    output logic [INDEX_SIZE-1:0]                          ram_a,
    output logic [TAG_SIZE+32*(2**WORD_OFF_SIZE)-1:0]      ram_d,
    output logic                                           ram_w_valid
);

    localparam int unsigned NWORDS   = 2 ** WORD_OFF_SIZE;
    localparam int unsigned DATA_W   = 32 * NWORDS;
    localparam int unsigned LINE_OFF = 2 + WORD_OFF_SIZE;

    typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE} state_t;

    state_t                   state;
    logic [TAG_SIZE-1:0]      tag;
    logic [INDEX_SIZE-1:0]    index;
    logic [WORD_OFF_SIZE-1:0] offset;
    logic [WORD_OFF_SIZE-1:0] beat_cnt;
    logic [31:0]              words [0:NWORDS-2];
    logic [DATA_W-1:0]        line_c;
    logic                     last_beat_c;
    logic                     unused_addr_bits;

    assign last_beat_c      = (beat_cnt == WORD_OFF_SIZE'(NWORDS - 1));
    assign unused_addr_bits = ^miss_addr[1:0];

    // The final beat bypasses the buffer so the line is complete on the WRITE edge.
    always_comb begin
        line_c = '0;
        for (int i = 0; i < int'(NWORDS) - 1; i++) begin
            line_c[32*i +: 32] = words[i];
        end
        line_c[DATA_W-1 -: 32] = mem_rdata;
    end

    // Beat buffer for words 0..NWORDS-2; payload only, so no reset.
    always_ff @(posedge clk) begin
        if (state == RECV && mem_rvalid) begin
            for (int i = 0; i < int'(NWORDS) - 1; i++) begin
                if (beat_cnt == WORD_OFF_SIZE'(i)) begin
                    words[i] <= mem_rdata;
                end
            end
        end
    end

    // Refill FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            tag          <= '0;
            index        <= '0;
            offset       <= '0;
            beat_cnt     <= '0;
            refill_busy  <= 1'b0;
            refill_done  <= 1'b0;
            crit_valid   <= 1'b0;
            crit_data    <= '0;
            protocol_err <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= '0;
            ram_wen      <= 1'b0;
            ram_a        <= '0;
            ram_d        <= '0;
            ram_w_valid  <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            crit_valid  <= 1'b0;
            ram_wen     <= 1'b0;
            ram_w_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        tag         <= miss_addr[31 -: TAG_SIZE];
                        index       <= miss_addr[LINE_OFF +: INDEX_SIZE];
                        offset      <= miss_addr[2 +: WORD_OFF_SIZE];
                        mem_rd_addr <= {miss_addr[31:LINE_OFF], LINE_OFF'(0)};
                        mem_rd_req  <= 1'b1;
                        refill_busy <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + WORD_OFF_SIZE'(1);
                        if (beat_cnt == offset) begin
                            crit_valid <= 1'b1;
                            crit_data  <= mem_rdata;
                        end
                        // Beat counter stays authoritative; rlast is only audited.
                        if (mem_rlast != last_beat_c) begin
                            protocol_err <= 1'b1;
                        end
                        if (last_beat_c) begin
                            ram_wen     <= 1'b1;
                            ram_w_valid <= 1'b1;
                            ram_a       <= index;
                            ram_d       <= {tag, line_c};
                            state       <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    refill_done <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    refill_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
